// File: rtl/isr_pkg.sv
// Shared width helpers and request-priority encoding for the push shift register.
package isr_pkg;

  // Shift/threshold field width: enough bits to encode 1..WIDTH-1, with 0 standing for WIDTH.
  function automatic int unsigned sw_of(input int unsigned width);
    return $clog2(width);
  endfunction

  // Count width: must hold the value WIDTH itself.
  function automatic int unsigned cw_of(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  // Winning request for the cycle, highest priority first after REQ_NONE.
  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_SET,
    REQ_PUSH,
    REQ_SHIFT
  } req_e;

endpackage

// File: rtl/isr_push_if.sv
// Request, data and push-slot handshake bundle for isr_push.
interface isr_push_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned CW = isr_pkg::cw_of(WIDTH);
  localparam int unsigned SW = isr_pkg::sw_of(WIDTH);

  logic             penable;
  logic [WIDTH-1:0] din;
  logic             do_shift;
  logic [SW-1:0]    shift;
  logic             dir;
  logic             set;
  logic [CW-1:0]    set_count;
  logic             push_req;
  logic             push_block;
  logic             autopush;
  logic [SW-1:0]    thresh;
  logic             push_ready;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] push_data;
  logic             push_valid;
  logic             stall;

  // Requester / downstream side.
  modport master (
    output penable, din, do_shift, shift, dir, set, set_count,
    output push_req, push_block, autopush, thresh, push_ready,
    input  dout, count, push_data, push_valid, stall
  );

  // Shift register side.
  modport slave (
    input  penable, din, do_shift, shift, dir, set, set_count,
    input  push_req, push_block, autopush, thresh, push_ready,
    output dout, count, push_data, push_valid, stall
  );

endinterface

// File: rtl/isr_shift_unit.sv
// Combinational shifter: computes the post-shift register value and saturating bit count.
module isr_shift_unit import isr_pkg::*; #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CW = cw_of(WIDTH),
  localparam int unsigned SW = sw_of(WIDTH)
) (
  input  logic [WIDTH-1:0] sr,
  input  logic [WIDTH-1:0] din,
  input  logic [SW-1:0]    shift,
  input  logic             dir,
  input  logic [CW-1:0]    count,
  output logic [WIDTH-1:0] sr_next,
  output logic [CW-1:0]    count_next
);

  localparam logic [CW-1:0] WidthC = CW'(WIDTH);

  logic [CW-1:0]    n;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] din_m;
  logic [CW:0]      sum;

  // Shift by n in 1..WIDTH; a shift by WIDTH empties sr and the mask becomes all ones,
  // so the full-width case falls out of the general expressions.
  always_comb begin
    n     = (shift == '0) ? WidthC : {1'b0, shift};
    mask  = ~({WIDTH{1'b1}} << n);
    din_m = din & mask;
    if (dir) begin
      sr_next = (sr >> n) | (din_m << (WidthC - n));
    end else begin
      sr_next = (sr << n) | din_m;
    end
    sum        = {1'b0, count} + {1'b0, n};
    count_next = (sum > {1'b0, WidthC}) ? WidthC : sum[CW-1:0];
  end

endmodule

// File: rtl/isr_push.sv
// Input shift register with a one-entry push slot, explicit and automatic push.
module isr_push import isr_pkg::*; #(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       reset_n,
  isr_push_if.slave bus
);

  localparam int unsigned CW = cw_of(WIDTH);
  localparam logic [CW-1:0] WidthC = CW'(WIDTH);

  logic [WIDTH-1:0] sr_q, sr_d, sh_sr, load_val;
  logic [CW-1:0]    cnt_q, cnt_d, sh_cnt, thr;
  logic [WIDTH-1:0] pdata_q, pdata_d;
  logic             pvalid_q, pvalid_d;
  logic             slot_free, auto_hit, load, stall;
  req_e             req;

  isr_shift_unit #(
    .WIDTH(WIDTH)
  ) u_shift (
    .sr        (sr_q),
    .din       (bus.din),
    .shift     (bus.shift),
    .dir       (bus.dir),
    .count     (cnt_q),
    .sr_next   (sh_sr),
    .count_next(sh_cnt)
  );

  // Pick the single winning request; penable low suppresses all of them.
  always_comb begin
    req = REQ_NONE;
    if (bus.penable) begin
      if (bus.set)           req = REQ_SET;
      else if (bus.push_req) req = REQ_PUSH;
      else if (bus.do_shift) req = REQ_SHIFT;
    end
  end

  assign slot_free = !pvalid_q || bus.push_ready;
  assign thr       = (bus.thresh == '0) ? WidthC : {1'b0, bus.thresh};
  assign auto_hit  = bus.autopush && (sh_cnt >= thr);

  // Next shift state, slot load request and stall for the winning request.
  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    load_val = sr_q;
    stall    = 1'b0;
    unique case (req)
      REQ_NONE: ;
      REQ_SET: begin
        sr_d  = bus.din;
        cnt_d = bus.set_count;
      end
      REQ_PUSH: begin
        if (slot_free) begin
          load  = 1'b1;
          sr_d  = '0;
          cnt_d = '0;
        end else if (bus.push_block) begin
          stall = 1'b1;
        end else begin
          // Non-blocking push into a full slot drops the data.
          sr_d  = '0;
          cnt_d = '0;
        end
      end
      REQ_SHIFT: begin
        if (auto_hit) begin
          if (slot_free) begin
            load     = 1'b1;
            load_val = sh_sr;
            sr_d     = '0;
            cnt_d    = '0;
          end else begin
            stall = 1'b1;
          end
        end else begin
          sr_d  = sh_sr;
          cnt_d = sh_cnt;
        end
      end
    endcase
  end

  // Slot: a new load wins over draining, giving back-to-back pushes without a bubble.
  always_comb begin
    pdata_d  = pdata_q;
    pvalid_d = pvalid_q;
    if (load) begin
      pdata_d  = load_val;
      pvalid_d = 1'b1;
    end else if (pvalid_q && bus.push_ready) begin
      pvalid_d = 1'b0;
    end
  end

  // All state, cleared asynchronously; a pending push is discarded on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q     <= '0;
      cnt_q    <= '0;
      pdata_q  <= '0;
      pvalid_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      pdata_q  <= pdata_d;
      pvalid_q <= pvalid_d;
    end
  end

  assign bus.dout       = sr_q;
  assign bus.count      = cnt_q;
  assign bus.push_data  = pdata_q;
  assign bus.push_valid = pvalid_q;
  assign bus.stall      = stall;

endmodule

// File: tb/tb_isr_push.sv
// Directed bench for isr_push at WIDTH=32 with hand-computed expectations.
module tb_isr_push;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  isr_push_if #(.WIDTH(32)) bus ();

  isr_push #(
    .WIDTH(32)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.do_shift = 1'b0;
    bus.set      = 1'b0;
    bus.push_req = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    bus.penable    = 1'b1;
    bus.din        = '0;
    bus.do_shift   = 1'b0;
    bus.shift      = '0;
    bus.dir        = 1'b0;
    bus.set        = 1'b0;
    bus.set_count  = '0;
    bus.push_req   = 1'b0;
    bus.push_block = 1'b0;
    bus.autopush   = 1'b0;
    bus.thresh     = '0;
    bus.push_ready = 1'b0;
    #12;
    check("rst_dout", 64'(bus.dout), 64'h0);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_pvalid", 64'(bus.push_valid), 64'd0);
    check("rst_pdata", 64'(bus.push_data), 64'h0);
    check("rst_stall", 64'(bus.stall), 64'd0);
    reset_n = 1'b1;
    cyc();

    // Left shift 8 four times, autopush off.
    bus.dir = 1'b0; bus.shift = 5'd8; bus.do_shift = 1'b1;
    bus.din = 32'h11; cyc();
    check("l8_1_dout", 64'(bus.dout), 64'h11);
    check("l8_1_count", 64'(bus.count), 64'd8);
    bus.din = 32'h22; cyc();
    bus.din = 32'h33; cyc();
    bus.din = 32'h44; cyc();
    check("l8_4_dout", 64'(bus.dout), 64'h11223344);
    check("l8_4_count", 64'(bus.count), 64'd32);
    bus.din = 32'h55; cyc();
    check("l8_sat_dout", 64'(bus.dout), 64'h22334455);
    check("l8_sat_count", 64'(bus.count), 64'd32);
    // shift = 0 means full width: din lands unchanged.
    bus.shift = 5'd0; bus.din = 32'hA5A51234; cyc();
    check("lfull_dout", 64'(bus.dout), 64'hA5A51234);

    // set beats a concurrent shift.
    bus.set = 1'b1; bus.din = 32'hCAFEF00D; bus.set_count = 6'd12; bus.shift = 5'd8; cyc();
    check("set_dout", 64'(bus.dout), 64'hCAFEF00D);
    check("set_count", 64'(bus.count), 64'd12);
    bus.set = 1'b0;

    // Right shift 4: low nibble of din enters at the MSB end.
    bus.dir = 1'b1; bus.shift = 5'd4; bus.din = 32'h0000000B; cyc();
    check("r4_dout", 64'(bus.dout), 64'hBCAFEF00);
    check("r4_count", 64'(bus.count), 64'd16);

    // penable low freezes the shift state.
    bus.penable = 1'b0; #1;
    check("pen_stall", 64'(bus.stall), 64'd0);
    cyc();
    check("pen_dout", 64'(bus.dout), 64'hBCAFEF00);
    check("pen_count", 64'(bus.count), 64'd16);
    bus.penable = 1'b1;

    // Clear, then right shift 8 of 0x5A with autopush at 8.
    idle();
    bus.set = 1'b1; bus.din = '0; bus.set_count = '0; cyc();
    bus.set = 1'b0;
    bus.dir = 1'b1; bus.shift = 5'd8; bus.din = 32'h5A; bus.autopush = 1'b1;
    bus.thresh = 5'd8; bus.push_ready = 1'b1; bus.do_shift = 1'b1; #1;
    check("ap_stall", 64'(bus.stall), 64'd0);
    cyc();
    check("ap_pvalid", 64'(bus.push_valid), 64'd1);
    check("ap_pdata", 64'(bus.push_data), 64'h5A000000);
    check("ap_dout", 64'(bus.dout), 64'h0);
    check("ap_count", 64'(bus.count), 64'd0);
    idle(); cyc();
    check("ap_drain", 64'(bus.push_valid), 64'd0);

    // Below threshold: no push.
    bus.dir = 1'b0; bus.thresh = 5'd16; bus.din = 32'h11; bus.do_shift = 1'b1; cyc();
    check("thr_dout", 64'(bus.dout), 64'h11);
    check("thr_pvalid", 64'(bus.push_valid), 64'd0);

    // Fill the slot with push_ready low.
    idle(); bus.push_ready = 1'b0; bus.push_req = 1'b1; cyc();
    check("fill_pdata", 64'(bus.push_data), 64'h11);
    check("fill_pvalid", 64'(bus.push_valid), 64'd1);
    check("fill_dout", 64'(bus.dout), 64'h0);

    // Autopush into the full slot stalls and holds.
    idle(); bus.shift = 5'd0; bus.thresh = 5'd0; bus.din = 32'h12345678; bus.do_shift = 1'b1;
    #1;
    check("full_stall", 64'(bus.stall), 64'd1);
    cyc();
    check("full_pdata", 64'(bus.push_data), 64'h11);
    check("full_dout", 64'(bus.dout), 64'h0);
    check("full_count", 64'(bus.count), 64'd0);
    check("full_stall2", 64'(bus.stall), 64'd1);
    bus.push_ready = 1'b1; #1;
    check("rdy_stall", 64'(bus.stall), 64'd0);
    cyc();
    check("b2b_pvalid", 64'(bus.push_valid), 64'd1);
    check("b2b_pdata", 64'(bus.push_data), 64'h12345678);
    check("b2b_count", 64'(bus.count), 64'd0);
    idle(); cyc();
    check("b2b_drain", 64'(bus.push_valid), 64'd0);

    // Full slot, non-blocking push drops data.
    bus.autopush = 1'b0; bus.push_ready = 1'b0;
    bus.set = 1'b1; bus.din = 32'h77; bus.set_count = 6'd8; cyc();
    bus.set = 1'b0; bus.push_req = 1'b1; cyc();
    idle(); bus.set = 1'b1; bus.din = 32'hDEADBEEF; bus.set_count = 6'd32; cyc();
    bus.set = 1'b0; bus.push_req = 1'b1; bus.push_block = 1'b0; #1;
    check("drop_stall", 64'(bus.stall), 64'd0);
    cyc();
    check("drop_pdata", 64'(bus.push_data), 64'h77);
    check("drop_dout", 64'(bus.dout), 64'h0);
    check("drop_count", 64'(bus.count), 64'd0);

    // Full slot, blocking push stalls and changes nothing.
    idle(); bus.set = 1'b1; cyc();
    bus.set = 1'b0; bus.push_req = 1'b1; bus.push_block = 1'b1; #1;
    check("blk_stall", 64'(bus.stall), 64'd1);
    cyc();
    check("blk_dout", 64'(bus.dout), 64'hDEADBEEF);
    check("blk_count", 64'(bus.count), 64'd32);
    check("blk_pdata", 64'(bus.push_data), 64'h77);

    // Asynchronous reset mid-handshake.
    idle(); #1;
    reset_n = 1'b0; #1;
    check("arst_pvalid", 64'(bus.push_valid), 64'd0);
    check("arst_pdata", 64'(bus.push_data), 64'h0);
    check("arst_dout", 64'(bus.dout), 64'h0);
    check("arst_count", 64'(bus.count), 64'd0);
    #1 reset_n = 1'b1;
    bus.push_ready = 1'b1; cyc(); cyc();
    check("arst_nopush", 64'(bus.push_valid), 64'd0);
    check("arst_pdata2", 64'(bus.push_data), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/isr_push.md
ISR_PUSH -- requirements
Module: isr_push

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning shift register width in bits (legal 8..64, power of two).
REQ-002 The block SHALL have derived constants CW = clog2(WIDTH)+1 (count width) and SW = clog2(WIDTH) (shift/threshold field width).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port penable  input  1  state-machine enable; low freezes shift state.
REQ-006 Port din  input  WIDTH  shift-in source / set value.
REQ-007 Port do_shift  input  1  shift request.
REQ-008 Port shift  input  SW  shift amount; 0 means WIDTH.
REQ-009 Port dir  input  1  1 = shift right (data enters at MSB), 0 = shift left (data enters at LSB).
REQ-010 Port set  input  1  load din into the register.
REQ-011 Port set_count  input  CW  count value loaded with set.
REQ-012 Port push_req  input  1  explicit push request.
REQ-013 Port push_block  input  1  explicit push blocks (1) or drops (0) when the slot is full.
REQ-014 Port autopush  input  1  enable automatic push at threshold.
REQ-015 Port thresh  input  SW  autopush threshold; 0 means WIDTH.
REQ-016 Port push_ready  input  1  downstream FIFO accepts push_data.
REQ-017 Port dout  output  WIDTH  current shift register contents.
REQ-018 Port count  output  CW  bits shifted in, saturating at WIDTH.
REQ-019 Port push_data / push_valid  output  WIDTH / 1  one-entry push slot, valid/ready handshake.
REQ-020 Port stall  output  1  combinational; current request cannot complete this cycle.

Function
REQ-021 Shift by n (1..WIDTH): left: new = (sr << n) | din[n-1:0]; right: new = (sr >> n) | (din[n-1:0] << (WIDTH-n)); n = WIDTH yields din unchanged.
REQ-022 On shift, count SHALL become min(count + n, WIDTH).
REQ-023 Request priority per cycle SHALL be set > push_req > do_shift; lower-priority requests in the same cycle are ignored.
REQ-024 With penable low, dout and count SHALL hold; the push slot handshake SHALL still operate.
REQ-025 Slot is "free" when push_valid = 0 or push_ready = 1 in the same cycle.
REQ-026 Autopush: if autopush = 1 and the post-shift count >= thresh (0 = WIDTH), the shifted value SHALL load push_data, push_valid SHALL rise next cycle, sr and count SHALL clear to 0.
REQ-027 Autopush with slot not free: stall = 1, sr, count and slot SHALL hold; the shift retries on a later cycle.
REQ-028 Explicit push with slot free: push_data <= sr, push_valid <= 1, sr and count cleared.
REQ-029 Explicit push, slot not free, push_block = 1: stall = 1, nothing changes.
REQ-030 Explicit push, slot not free, push_block = 0: stall = 0, data dropped, push_data unchanged, sr and count cleared.
REQ-031 push_valid SHALL clear the cycle after push_valid & push_ready unless a new push loads the slot in that same cycle (back-to-back without a bubble).
REQ-032 push_data SHALL be stable while push_valid = 1 and push_ready = 0.
REQ-033 stall SHALL be 0 whenever penable = 0 or no push-triggering request is present.

Reset
REQ-034 reset_n low SHALL immediately clear sr, count, push_data and push_valid to 0, including mid-handshake; a pending push is discarded.
REQ-035 After reset: dout = 0, count = 0, push_valid = 0, push_data = 0, stall = 0 (with no requests).

Structure
REQ-036 Package isr_pkg SHALL hold the CW/SW width functions and the request-priority enum (REQ_NONE, REQ_SET, REQ_PUSH, REQ_SHIFT).
REQ-037 The combinational shifter (REQ-021, REQ-022) SHALL be the sub-module isr_shift_unit; the slot and control logic stay in isr_push.

Verification
REQ-038 WIDTH=32: left shift 8 bits four times with din = 0x11, 0x22, 0x33, 0x44 and autopush off -> dout = 0x11223344, count = 32.
REQ-039 Right shift 8 of din = 0x5A, autopush = 1, thresh = 8, push_ready = 1 -> next cycle push_valid = 1, push_data = 0x5A000000, dout = 0, count = 0.
REQ-040 Slot full with push_ready = 0, then autopush-triggering shift -> stall = 1 and state held; raise push_ready -> transfer completes, shift lands, new push_valid follows with no bubble.
REQ-041 Slot full, push_req with push_block = 0 and sr = 0xDEADBEEF -> stall = 0, push_data unchanged, dout = 0, count = 0.
REQ-042 set with din = 0xCAFEF00D and set_count = 12, concurrent do_shift -> dout = 0xCAFEF00D, count = 12, shift ignored.
REQ-043 reset_n pulsed low between clock edges while push_valid = 1 -> all outputs 0 immediately, no transfer after release.
